serial_byte_deser: RTL and testbench
====================================

Name: serial_byte_deser

Overview:
- Downstream consumer of the single-bit D flip-flop stage: samples the flop's registered output `q` as a framed serial stream and assembles data words.
- Frame format, LSB first: start bit (0), DATA_W data bits, stop bit (1).
- Completed words are buffered in a small FIFO and presented on a valid/ready output port.
- Framing errors and FIFO overflow are flagged for the scoreboard and monitor.

Parameters:
- DATA_W, 8, data bits per frame (1..16).
- FIFO_DEPTH, 4, word buffer entries; must be a power of 2, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- bit_in  input  1  serial bit; driven from the D flip-flop `q`.
- bit_valid  input  1  bit_in is sampled only on edges where this is 1.
- out_data  output  DATA_W  FIFO head word.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head word on an edge where out_valid && out_ready.
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- overflow  output  1  sticky; set when a good word is dropped because the FIFO is full.
- clr_ovf  input  1  synchronous clear of overflow.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of stored words.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; shift register, bit counter and FIFO pointers clear.
  - out_valid=0, out_data=0, frame_err=0, overflow=0, fifo_count=0.
  - Reset release is synchronous to clk.
- The FSM advances only on edges with bit_valid=1; with bit_valid=0 all FSM state holds.
- IDLE:
  - bit_in=0 -> DATA with the bit counter at 0.
  - bit_in=1 -> stay in IDLE (line idle).
- DATA:
  - bit_in shifts into position `cnt` (LSB first); cnt increments.
  - After the DATA_W-th data bit -> STOP.
- STOP, bit_in=1 (good frame):
  - Word is pushed to the FIFO on this edge; FSM -> IDLE.
  - If the FIFO was empty, out_valid=1 and out_data=word immediately after this edge (latency 0 cycles from the stop edge).
- STOP, bit_in=0 (bad frame):
  - Word discarded; frame_err=1 for exactly the following cycle; FSM -> IDLE.
  - A 0 stop bit is not reinterpreted as a new start bit; the next frame needs a fresh start bit after IDLE is re-entered.
- FIFO:
  - Pop on an edge with out_valid && out_ready.
  - out_data is the combinational head word; it is 0 when empty.
- Simultaneous push and pop: count unchanged. When full, this combination is accepted without overflow.
- Push while full with no pop: word dropped, overflow set to 1, count stays FIFO_DEPTH.
- overflow stays set until clr_ovf=1 on an edge. If clr_ovf and a new drop occur on the same edge, the drop wins (overflow stays 1).
- Pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
- out_ready while empty has no effect.
- Reset mid-frame or with the FIFO partially filled discards everything; the bench must not expect any word afterwards.
- Frame bits separated by bit_valid=0 gaps of any length assemble identically to back-to-back bits.

Test Plan:
- Basic frame:
  - Stimulus: rst low 2 ns then high. Frame 0, bits of 8'hA5 LSB first (1,0,1,0,0,1,0,1), stop 1, bit_valid=1 every cycle, out_ready=0.
  - Required: out_valid=1 and out_data=8'hA5 right after the stop edge; fifo_count=1; frame_err never asserted.
- Framing error:
  - Stimulus: start, bits of 8'h3C, stop=0.
  - Required: frame_err pulses for 1 cycle; fifo_count unchanged. The next valid frame 8'h81 is received correctly.
- Overflow and simultaneous push/pop:
  - Stimulus: out_ready=0, send 5 frames 8'h01..8'h05.
  - Required after frames 1-4: fifo_count=4.
  - Required after frame 5: overflow=1; 8'h05 is lost.
  - Stimulus: clr_ovf pulse. Required: overflow=0.
  - Stimulus: drain with out_ready=1. Required: reads 01,02,03,04.
  - Stimulus: repeat with FIFO full, out_ready=1 on the stop edge. Required: no overflow.
- Gapped input:
  - Stimulus: frame 8'h5A with bit_valid toggling 1/0 and random 0-3 cycle gaps.
  - Required: out_data=8'h5A with identical result to the ungapped case.
- Reset mid-operation:
  - Stimulus: two words in the FIFO plus half a frame shifted in; assert rst=0 asynchronously between clock edges.
  - Required: outputs clear immediately (out_valid=0, fifo_count=0).
  - Stimulus: after release, a new frame 8'hC3. Required: it is the only word delivered.

Source files
------------

// File: rtl/serial_byte_deser_if.sv
// Bundles the serial input, word output stream and status signals of serial_byte_deser.
// Clock and reset stay outside the interface.
interface serial_byte_deser_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                          bit_in;
    logic                          bit_valid;
    logic [DATA_W-1:0]             out_data;
    logic                          out_valid;
    logic                          out_ready;
    logic                          frame_err;
    logic                          overflow;
    logic                          clr_ovf;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    modport master (
        output bit_in, bit_valid, out_ready, clr_ovf,
        input  out_data, out_valid, frame_err, overflow, fifo_count
    );

    modport slave (
        input  bit_in, bit_valid, out_ready, clr_ovf,
        output out_data, out_valid, frame_err, overflow, fifo_count
    );
endinterface

// File: rtl/serial_byte_deser.sv
// Deserialises start/data/stop framed bits (LSB first) into words and buffers them
// in a small FIFO with valid/ready output, framing-error pulse and sticky overflow.
//
// state  | meaning
// S_IDLE | line idle, waiting for a 0 start bit
// S_DATA | shifting in DATA_W data bits, cnt = next bit position
// S_STOP | expecting the 1 stop bit; good word is pushed, bad one discarded
module serial_byte_deser #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    serial_byte_deser_if.slave bus
);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BIT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               frame_err_q, frame_err_d;
    logic               push_req;

    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               full, pop, do_push, drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push_req    = 1'b0;
        if (bus.bit_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (!bus.bit_in) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end
                end
                S_DATA: begin
                    shift_d[cnt_q] = bus.bit_in;
                    if (cnt_q == LAST_BIT) begin
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + BIT_ONE;
                    end
                end
                S_STOP: begin
                    // a 0 stop bit only returns to IDLE; it never doubles as a start bit
                    if (bus.bit_in) begin
                        push_req = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        full     = (count_q == FULL_CNT);
        pop      = (count_q != '0) && bus.out_ready;
        // a pop on the same edge frees the slot, so a full FIFO still accepts the push
        do_push  = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    assign bus.out_valid  = (count_q != '0);
    assign bus.out_data   = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.fifo_count = count_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_serial_byte_deser.sv
// Directed, table-driven bench for serial_byte_deser: frame/pop/clear vectors with
// hand-computed FIFO contents, plus a hand-written mid-operation reset sequence.
`timescale 1ns/1ps
module tb_serial_byte_deser;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {OP_FRAME, OP_POP, OP_CLR} op_e;

    typedef struct {
        op_e        op;
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic       rdy;
        logic       clr;
        logic [2:0] e_count;
        logic [7:0] e_head;
        logic       e_err;
        logic       e_ovf;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    serial_byte_deser_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    serial_byte_deser #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap_max, input logic rdy, input logic clr);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        for (int k = 0; k < g; k++) begin
            bus.bit_in    = ~b;
            bus.bit_valid = 1'b0;
            tick();
        end
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        bus.out_ready = rdy;
        bus.clr_ovf   = clr;
        tick();
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b1;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap_max,
                              input logic rdy, input logic clr);
        send_bit(1'b0, gap_max, 1'b0, 1'b0);
        for (int k = 0; k < DATA_W; k++) begin
            send_bit(d[k], gap_max, 1'b0, 1'b0);
        end
        send_bit(stop, gap_max, rdy, clr);
    endtask

    function automatic void add(input op_e op, input logic [7:0] data, input logic stop,
                                input int gap, input logic rdy, input logic clr,
                                input logic [2:0] e_count, input logic [7:0] e_head,
                                input logic e_err, input logic e_ovf);
        vec_t v;
        v.op = op; v.data = data; v.stop = stop; v.gap = gap; v.rdy = rdy; v.clr = clr;
        v.e_count = e_count; v.e_head = e_head; v.e_err = e_err; v.e_ovf = e_ovf;
        vecs.push_back(v);
    endfunction

    initial begin
        vec_t v;
        rst           = 1'b0;
        bus.bit_in    = 1'b1;
        bus.bit_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;

        //   op        data  stp gap rdy clr  cnt head  err ovf
        add(OP_FRAME, 8'hA5, 1, 0, 0, 0, 3'd1, 8'hA5, 0, 0);
        add(OP_FRAME, 8'h3C, 0, 0, 0, 0, 3'd1, 8'hA5, 1, 0);
        add(OP_FRAME, 8'h81, 1, 0, 0, 0, 3'd2, 8'hA5, 0, 0);
        add(OP_POP,   8'hA5, 0, 0, 0, 0, 3'd1, 8'h81, 0, 0);
        add(OP_POP,   8'h81, 0, 0, 0, 0, 3'd0, 8'h00, 0, 0);
        add(OP_POP,   8'h00, 0, 0, 0, 0, 3'd0, 8'h00, 0, 0);
        add(OP_FRAME, 8'h01, 1, 0, 0, 0, 3'd1, 8'h01, 0, 0);
        add(OP_FRAME, 8'h02, 1, 0, 0, 0, 3'd2, 8'h01, 0, 0);
        add(OP_FRAME, 8'h03, 1, 0, 0, 0, 3'd3, 8'h01, 0, 0);
        add(OP_FRAME, 8'h04, 1, 0, 0, 0, 3'd4, 8'h01, 0, 0);
        add(OP_FRAME, 8'h05, 1, 0, 0, 0, 3'd4, 8'h01, 0, 1);
        add(OP_CLR,   8'h00, 0, 0, 0, 0, 3'd4, 8'h01, 0, 0);
        add(OP_POP,   8'h01, 0, 0, 0, 0, 3'd3, 8'h02, 0, 0);
        add(OP_POP,   8'h02, 0, 0, 0, 0, 3'd2, 8'h03, 0, 0);
        add(OP_POP,   8'h03, 0, 0, 0, 0, 3'd1, 8'h04, 0, 0);
        add(OP_POP,   8'h04, 0, 0, 0, 0, 3'd0, 8'h00, 0, 0);
        add(OP_FRAME, 8'h11, 1, 0, 0, 0, 3'd1, 8'h11, 0, 0);
        add(OP_FRAME, 8'h22, 1, 0, 0, 0, 3'd2, 8'h11, 0, 0);
        add(OP_FRAME, 8'h33, 1, 0, 0, 0, 3'd3, 8'h11, 0, 0);
        add(OP_FRAME, 8'h44, 1, 0, 0, 0, 3'd4, 8'h11, 0, 0);
        add(OP_FRAME, 8'h55, 1, 0, 1, 0, 3'd4, 8'h22, 0, 0);
        add(OP_FRAME, 8'h66, 1, 0, 0, 0, 3'd4, 8'h22, 0, 1);
        add(OP_FRAME, 8'h77, 1, 0, 0, 1, 3'd4, 8'h22, 0, 1);
        add(OP_CLR,   8'h00, 0, 0, 0, 0, 3'd4, 8'h22, 0, 0);
        add(OP_POP,   8'h22, 0, 0, 0, 0, 3'd3, 8'h33, 0, 0);
        add(OP_POP,   8'h33, 0, 0, 0, 0, 3'd2, 8'h44, 0, 0);
        add(OP_POP,   8'h44, 0, 0, 0, 0, 3'd1, 8'h55, 0, 0);
        add(OP_POP,   8'h55, 0, 0, 0, 0, 3'd0, 8'h00, 0, 0);
        add(OP_FRAME, 8'h5A, 1, 3, 0, 0, 3'd1, 8'h5A, 0, 0);
        add(OP_FRAME, 8'h5A, 1, 0, 0, 0, 3'd2, 8'h5A, 0, 0);
        add(OP_POP,   8'h5A, 0, 0, 0, 0, 3'd1, 8'h5A, 0, 0);
        add(OP_POP,   8'h5A, 0, 0, 0, 0, 3'd0, 8'h00, 0, 0);

        #1;
        check("reset_valid", 32'(bus.out_valid), 32'd0);
        check("reset_count", 32'(bus.fifo_count), 32'd0);
        check("reset_data",  32'(bus.out_data), 32'd0);
        check("reset_err",   32'(bus.frame_err), 32'd0);
        check("reset_ovf",   32'(bus.overflow), 32'd0);
        #1 rst = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            case (v.op)
                OP_FRAME: send_frame(v.data, v.stop, v.gap, v.rdy, v.clr);
                OP_POP: begin
                    check($sformatf("pop_data[%0d]", i), 32'(bus.out_data), 32'(v.data));
                    bus.out_ready = 1'b1;
                    tick();
                    bus.out_ready = 1'b0;
                end
                default: begin
                    bus.clr_ovf = 1'b1;
                    tick();
                    bus.clr_ovf = 1'b0;
                end
            endcase
            check($sformatf("count[%0d]", i), 32'(bus.fifo_count), 32'(v.e_count));
            check($sformatf("valid[%0d]", i), 32'(bus.out_valid), 32'(v.e_count != 3'd0));
            check($sformatf("head[%0d]", i),  32'(bus.out_data), 32'(v.e_head));
            check($sformatf("err[%0d]", i),   32'(bus.frame_err), 32'(v.e_err));
            check($sformatf("ovf[%0d]", i),   32'(bus.overflow), 32'(v.e_ovf));
            if (v.op == OP_FRAME) begin
                tick();
                check($sformatf("err_pulse_end[%0d]", i), 32'(bus.frame_err), 32'd0);
            end
        end

        // Reset with two stored words and half a frame shifted in
        send_frame(8'h12, 1'b1, 0, 1'b0, 1'b0);
        send_frame(8'h34, 1'b1, 0, 1'b0, 1'b0);
        check("pre_reset_count", 32'(bus.fifo_count), 32'd2);
        send_bit(1'b0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            send_bit(k[0], 0, 1'b0, 1'b0);
        end
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_count", 32'(bus.fifo_count), 32'd0);
        check("async_rst_data",  32'(bus.out_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        send_frame(8'hC3, 1'b1, 0, 1'b0, 1'b0);
        check("post_rst_count", 32'(bus.fifo_count), 32'd1);
        check("post_rst_head",  32'(bus.out_data), 32'hC3);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("post_rst_drained_count", 32'(bus.fifo_count), 32'd0);
        check("post_rst_drained_valid", 32'(bus.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
